// File: rtl/bru_issue_ctrl.sv
// In-order branch issue controller: buffers branch uops, issues the head to the
// resolve decoder, registers the outcome and sequences redirect on mispredict.
module bru_issue_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ROB_IDX_W = 6,
    parameter int unsigned PC_W      = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 enq_valid_in,
    output logic                 enq_ready_out,
    input  logic [ROB_IDX_W-1:0] enq_rob_idx_in,
    input  logic [PC_W-1:0]      enq_pc_in,
    input  logic                 enq_needs_flags_in,
    input  logic                 enq_pred_taken_in,
    input  logic [PC_W-1:0]      enq_pred_target_in,
    input  logic                 flags_valid_in,
    output logic                 issue_valid_out,
    output logic [ROB_IDX_W-1:0] issue_rob_idx_out,
    output logic [PC_W-1:0]      issue_pc_out,
    input  logic                 bru_taken_in,
    input  logic [PC_W-1:0]      bru_target_in,
    output logic                 resolve_valid_out,
    output logic [ROB_IDX_W-1:0] resolve_rob_idx_out,
    output logic                 mispredict_out,
    output logic                 redirect_valid_out,
    output logic [PC_W-1:0]      redirect_pc_out,
    input  logic                 redirect_ack_in,
    input  logic                 flush_in
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [ROB_IDX_W-1:0] q_idx         [DEPTH];
    logic [PC_W-1:0]      q_pc          [DEPTH];
    logic [PC_W-1:0]      q_pred_target [DEPTH];
    logic [DEPTH-1:0]     q_needs_flags;
    logic [DEPTH-1:0]     q_pred_taken;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;

    logic            enq_accept;
    logic            issue_fire;
    logic            mispredict;
    logic            flush_queue;
    logic [PC_W-1:0] actual_pc;

    always_comb begin
        enq_ready_out      = (state == RUN) && (count < CNT_W'(DEPTH));
        issue_valid_out    = (state == RUN) && (count != '0)
                             && (!q_needs_flags[rd_ptr] || flags_valid_in) && !flush_in;
        issue_rob_idx_out  = q_idx[rd_ptr];
        issue_pc_out       = q_pc[rd_ptr];
        redirect_valid_out = (state == REDIRECT);
        issue_fire         = issue_valid_out;
        mispredict         = (bru_taken_in != q_pred_taken[rd_ptr])
                             || (bru_taken_in && (bru_target_in != q_pred_target[rd_ptr]));
        actual_pc          = bru_taken_in ? bru_target_in : q_pc[rd_ptr] + PC_W'(4);
        // A mispredict or flush empties the queue, so that cycle's enqueue is dropped.
        flush_queue        = flush_in || (issue_fire && mispredict);
        enq_accept         = enq_valid_in && enq_ready_out && !flush_queue;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (issue_fire && mispredict) state_next = REDIRECT;
            REDIRECT: if (redirect_ack_in) state_next = RUN;
            default:  state_next = RUN;
        endcase
        if (flush_in) state_next = RUN;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= RUN;
        else        state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (enq_accept) begin
            q_idx[wr_ptr]         <= enq_rob_idx_in;
            q_pc[wr_ptr]          <= enq_pc_in;
            q_pred_target[wr_ptr] <= enq_pred_target_in;
            q_needs_flags[wr_ptr] <= enq_needs_flags_in;
            q_pred_taken[wr_ptr]  <= enq_pred_taken_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            resolve_valid_out   <= 1'b0;
            resolve_rob_idx_out <= '0;
            mispredict_out      <= 1'b0;
            redirect_pc_out     <= '0;
        end else begin
            resolve_valid_out <= issue_fire;
            mispredict_out    <= issue_fire && mispredict;
            if (issue_fire) resolve_rob_idx_out <= q_idx[rd_ptr];
            if (issue_fire && mispredict) redirect_pc_out <= actual_pc;
            if (flush_queue) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq_accept) wr_ptr <= wr_ptr + PTR_W'(1);
                if (issue_fire) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(enq_accept) - CNT_W'(issue_fire);
            end
        end
    end

endmodule

// File: tb/tb_bru_issue_ctrl.sv
// Directed bench for bru_issue_ctrl: queue-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_bru_issue_ctrl;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        enq_valid_in = 1'b0;
    logic        enq_ready_out;
    logic [5:0]  enq_rob_idx_in = '0;
    logic [63:0] enq_pc_in = '0;
    logic        enq_needs_flags_in = 1'b0;
    logic        enq_pred_taken_in = 1'b0;
    logic [63:0] enq_pred_target_in = '0;
    logic        flags_valid_in = 1'b0;
    logic        issue_valid_out;
    logic [5:0]  issue_rob_idx_out;
    logic [63:0] issue_pc_out;
    logic        bru_taken_in = 1'b0;
    logic [63:0] bru_target_in = '0;
    logic        resolve_valid_out;
    logic [5:0]  resolve_rob_idx_out;
    logic        mispredict_out;
    logic        redirect_valid_out;
    logic [63:0] redirect_pc_out;
    logic        redirect_ack_in = 1'b0;
    logic        flush_in = 1'b0;

    bru_issue_ctrl #(.DEPTH(DEPTH), .ROB_IDX_W(6), .PC_W(64)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .enq_valid_in(enq_valid_in), .enq_ready_out(enq_ready_out),
        .enq_rob_idx_in(enq_rob_idx_in), .enq_pc_in(enq_pc_in),
        .enq_needs_flags_in(enq_needs_flags_in), .enq_pred_taken_in(enq_pred_taken_in),
        .enq_pred_target_in(enq_pred_target_in), .flags_valid_in(flags_valid_in),
        .issue_valid_out(issue_valid_out), .issue_rob_idx_out(issue_rob_idx_out),
        .issue_pc_out(issue_pc_out), .bru_taken_in(bru_taken_in),
        .bru_target_in(bru_target_in), .resolve_valid_out(resolve_valid_out),
        .resolve_rob_idx_out(resolve_rob_idx_out), .mispredict_out(mispredict_out),
        .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out),
        .redirect_ack_in(redirect_ack_in), .flush_in(flush_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] pc;
        logic        nf;
        logic        pt;
        logic [63:0] ptgt;
        logic        dt;
        logic [63:0] dtgt;
    } br_t;

    br_t         mq[$];
    logic        m_redirect = 1'b0;
    logic [63:0] m_redir_pc = '0;
    logic        m_res_valid = 1'b0;
    logic [5:0]  m_res_idx = '0;
    logic        m_res_mis = 1'b0;
    logic        e_dt = 1'b0;
    logic [63:0] e_dtgt = '0;

    int n_checks = 0;
    int n_errs = 0;
    logic [5:0] res_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return !m_redirect && (mq.size() < DEPTH);
    endfunction

    function automatic logic exp_issue();
        if (m_redirect || mq.size() == 0 || flush_in) return 1'b0;
        return !mq[0].nf || flags_valid_in;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_redirect  = 1'b0;
        m_res_valid = 1'b0;
    endtask

    // Apply the effect of the clock edge that just happened, using the inputs it saw.
    task automatic model_edge();
        logic fire, enq, mis;
        logic [63:0] actual;
        br_t h, n;
        if (rst_in) begin
            model_reset();
            return;
        end
        fire = exp_issue();
        enq = enq_valid_in && exp_ready();
        mis = 1'b0;
        actual = '0;
        m_res_valid = fire;
        if (fire) begin
            h = mq.pop_front();
            mis = (h.dt != h.pt) || (h.dt && (h.dtgt != h.ptgt));
            actual = h.dt ? h.dtgt : h.pc + 64'd4;
            m_res_idx = h.idx;
            m_res_mis = mis;
        end
        if (flush_in) begin
            mq.delete();
            m_redirect = 1'b0;
        end else if (fire && mis) begin
            mq.delete();
            m_redirect = 1'b1;
            m_redir_pc = actual;
        end else begin
            if (m_redirect && redirect_ack_in) m_redirect = 1'b0;
            if (enq) begin
                n.idx = enq_rob_idx_in; n.pc = enq_pc_in; n.nf = enq_needs_flags_in;
                n.pt = enq_pred_taken_in; n.ptgt = enq_pred_target_in;
                n.dt = e_dt; n.dtgt = e_dtgt;
                mq.push_back(n);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
        model_edge();
        bru_taken_in  = (mq.size() > 0) ? mq[0].dt : 1'b0;
        bru_target_in = (mq.size() > 0) ? mq[0].dtgt : '0;
    endtask

    task automatic put(input logic [5:0] idx, input logic [63:0] pc, input logic nf,
                       input logic pt, input logic [63:0] ptgt,
                       input logic dt, input logic [63:0] dtgt);
        enq_valid_in = 1'b1; enq_rob_idx_in = idx; enq_pc_in = pc;
        enq_needs_flags_in = nf; enq_pred_taken_in = pt; enq_pred_target_in = ptgt;
        e_dt = dt; e_dtgt = dtgt;
    endtask

    always @(negedge clk_in) begin
        chk("enq_ready", enq_ready_out, exp_ready());
        chk("issue_valid", issue_valid_out, exp_issue());
        if (exp_issue()) begin
            chk("issue_idx", issue_rob_idx_out, mq[0].idx);
            chk("issue_pc", issue_pc_out, mq[0].pc);
        end
        chk("resolve_valid", resolve_valid_out, m_res_valid);
        if (m_res_valid) begin
            chk("resolve_idx", resolve_rob_idx_out, m_res_idx);
            chk("mispredict", mispredict_out, m_res_mis);
        end
        chk("redirect_valid", redirect_valid_out, m_redirect);
        if (m_redirect) chk("redirect_pc", redirect_pc_out, m_redir_pc);
    end

    initial begin
        cycle();
        cycle();
        rst_in = 1'b0;
        #1;
        chk("rst_resolve", resolve_valid_out, 0);
        chk("rst_mispredict", mispredict_out, 0);
        chk("rst_redirect", redirect_valid_out, 0);
        chk("rst_issue", issue_valid_out, 0);
        chk("rst_ready", enq_ready_out, 1);

        // Correctly predicted BL
        put(6'd1, 64'h1000, 1'b0, 1'b1, 64'h1400, 1'b1, 64'h1400);
        cycle();
        enq_valid_in = 1'b0;
        #1;
        chk("t1_issue", issue_valid_out, 1);
        chk("t1_issue_pc", issue_pc_out, 64'h1000);
        cycle();
        #1;
        chk("t1_resolve", resolve_valid_out, 1);
        chk("t1_mispredict", mispredict_out, 0);
        chk("t1_redirect", redirect_valid_out, 0);

        // Taken B.cond predicted not-taken, two younger entries behind it
        put(6'd2, 64'h2000, 1'b1, 1'b0, 64'h0, 1'b1, 64'h2040);
        cycle();
        put(6'd3, 64'h2100, 1'b0, 1'b1, 64'h2200, 1'b1, 64'h2200);
        cycle();
        put(6'd4, 64'h2200, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        cycle();
        enq_valid_in = 1'b0;
        flags_valid_in = 1'b1;
        #1;
        chk("t2_issue", issue_valid_out, 1);
        chk("t2_issue_pc", issue_pc_out, 64'h2000);
        cycle();
        put(6'd9, 64'h9000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        #1;
        chk("t2_mispredict", mispredict_out, 1);
        chk("t2_redirect", redirect_valid_out, 1);
        chk("t2_redirect_pc", redirect_pc_out, 64'h2040);
        chk("t2_ready", enq_ready_out, 0);
        cycle();
        enq_valid_in = 1'b0;
        #1;
        chk("t2_redirect_pc2", redirect_pc_out, 64'h2040);
        cycle();
        redirect_ack_in = 1'b1;
        #1;
        chk("t2_redirect3", redirect_valid_out, 1);
        cycle();
        redirect_ack_in = 1'b0;
        #1;
        chk("t2_ack_redirect", redirect_valid_out, 0);
        chk("t2_ack_ready", enq_ready_out, 1);
        chk("t2_discarded", issue_valid_out, 0);

        // Not-taken B.cond predicted taken; ack the same cycle redirect rises
        put(6'd5, 64'h3000, 1'b1, 1'b1, 64'h3080, 1'b0, 64'h3080);
        cycle();
        enq_valid_in = 1'b0;
        #1;
        chk("t3_issue", issue_valid_out, 1);
        cycle();
        redirect_ack_in = 1'b1;
        #1;
        chk("t3_redirect_pc", redirect_pc_out, 64'h3004);
        chk("t3_mispredict", mispredict_out, 1);
        cycle();
        redirect_ack_in = 1'b0;
        #1;
        chk("t3_redirect_off", redirect_valid_out, 0);
        chk("t3_ready", enq_ready_out, 1);

        // Fill with flags stalled, then drain; a full queue refuses even while popping
        flags_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(6'(10 + i), 64'h4000 + 64'(16 * i), 1'b1, 1'b1, 64'h4100 + 64'(16 * i),
                1'b1, 64'h4100 + 64'(16 * i));
            cycle();
        end
        put(6'd14, 64'h4040, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        #1;
        chk("t4_full_ready", enq_ready_out, 0);
        chk("t4_stall", issue_valid_out, 0);
        flags_valid_in = 1'b1;
        cycle();
        #1;
        chk("t4_ready_after_pop", enq_ready_out, 1);
        chk("t4_resolve_first", resolve_rob_idx_out, 10);
        cycle();
        enq_valid_in = 1'b0;
        repeat (6) cycle();
        #1;
        chk("t4_drained_issue", issue_valid_out, 0);
        chk("t4_drained_ready", enq_ready_out, 1);

        // Flush with entries queued and a capture just taken
        flags_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(6'(20 + i), 64'h5000 + 64'(8 * i), 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
            cycle();
        end
        enq_valid_in = 1'b0;
        flags_valid_in = 1'b1;
        cycle();
        flush_in = 1'b1;
        put(6'd23, 64'h5100, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        #1;
        chk("t5_prior_resolve", resolve_valid_out, 1);
        chk("t5_prior_idx", resolve_rob_idx_out, 20);
        chk("t5_flush_issue", issue_valid_out, 0);
        cycle();
        flush_in = 1'b0;
        enq_valid_in = 1'b0;
        #1;
        chk("t5_no_resolve", resolve_valid_out, 0);
        chk("t5_empty", issue_valid_out, 0);
        chk("t5_ready", enq_ready_out, 1);
        cycle();
        #1;
        chk("t5_enq_dropped", issue_valid_out, 0);

        // Flush while redirecting
        put(6'd24, 64'h6000, 1'b0, 1'b0, 64'h0, 1'b1, 64'h6800);
        cycle();
        enq_valid_in = 1'b0;
        cycle();
        #1;
        chk("t5b_redirect_pc", redirect_pc_out, 64'h6800);
        flush_in = 1'b1;
        cycle();
        flush_in = 1'b0;
        #1;
        chk("t5b_redirect_off", redirect_valid_out, 0);
        chk("t5b_ready", enq_ready_out, 1);

        // Streaming enqueue/issue across pointer wrap
        res_log.delete();
        for (int k = 0; k < 10; k++) begin
            put(6'(30 + k), 64'h7000 + 64'(4 * k), 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
            cycle();
            if (resolve_valid_out) res_log.push_back(resolve_rob_idx_out);
        end
        enq_valid_in = 1'b0;
        repeat (3) begin
            cycle();
            if (resolve_valid_out) res_log.push_back(resolve_rob_idx_out);
        end
        chk("t6_count", 64'(res_log.size()), 10);
        for (int k = 0; k < res_log.size() && k < 10; k++)
            chk("t6_order", res_log[k], 64'(30 + k));

        // Asynchronous reset mid-stall, then mid-redirect
        flags_valid_in = 1'b0;
        put(6'd40, 64'h8000, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        cycle();
        put(6'd41, 64'h8004, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        cycle();
        enq_valid_in = 1'b0;
        #2;
        rst_in = 1'b1;
        model_reset();
        #1;
        chk("t7_stall_issue", issue_valid_out, 0);
        chk("t7_stall_ready", enq_ready_out, 1);
        cycle();
        rst_in = 1'b0;
        put(6'd42, 64'h8100, 1'b0, 1'b1, 64'h8200, 1'b0, 64'h0);
        cycle();
        enq_valid_in = 1'b0;
        cycle();
        #1;
        chk("t7_redirect_pc", redirect_pc_out, 64'h8104);
        #1;
        rst_in = 1'b1;
        model_reset();
        #1;
        chk("t7_rst_redirect", redirect_valid_out, 0);
        chk("t7_rst_pc", redirect_pc_out, 0);
        cycle();
        rst_in = 1'b0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
